// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared state, opcode and control encodings for the multicycle core controller
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format depends only on the opcode; unknown opcodes fall back to I.
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/core_alu_decoder.sv
// rtl/core_alu_decoder.sv - maps ALUOp and instruction function fields to an ALU operation
import core_ctrl_pkg::*;

module core_alu_decoder (
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o,
  output logic       illegal_o
);

  // Decode the operation; illegal is raised only for an unsupported funct3 in funct mode.
  always_comb begin
    alu_control_o = ALU_ADD;
    illegal_o     = 1'b0;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: illegal_o = 1'b1;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/core_multicycle_ctrl.sv
// rtl/core_multicycle_ctrl.sv - Moore control FSM for a multicycle RV32I-subset core; CORE_MEM_WAIT_EN adds memory wait states
import core_ctrl_pkg::*;

module core_multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic        instr_done,
  output logic [31:0] instret,
  output logic        trap
);

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        trap_q, trap_d;
  logic [1:0]  alu_op;
  logic        funct_illegal;
  logic        mem_go;
  logic        pc_we, mem_we, ir_we, reg_we;
  logic        retire;

`ifdef CORE_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_go = 1'b1;
`endif

  core_alu_decoder u_alu_dec (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .op5_i         (op[5]),
    .alu_control_o (ALUControl),
    .illegal_o     (funct_illegal)
  );

  // State, retired count and sticky trap registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= 32'd0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
    end
  end

  // Next state and per-state datapath controls, defaults first.
  always_comb begin
    state_d   = state_q;
    pc_we     = 1'b0;
    AdrSrc    = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    alu_op    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_we     = mem_go;
        pc_we     = mem_go;
        if (mem_go) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_go) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_we    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_we = 1'b1;
        if (mem_go) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
        state_d = funct_illegal ? S_ILLEGAL : S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = funct_illegal ? S_ILLEGAL : S_ALUWB;
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_SUB;
        pc_we   = Zero;
        state_d = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        pc_we   = 1'b1;
        state_d = S_ALUWB;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase
  end

  // An instruction retires when a final state hands control back to FETCH.
  always_comb begin
    retire = 1'b0;
    if (!reset && state_d == S_FETCH) begin
      case (state_q)
        S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
    instret_d = instret_q + {31'd0, retire};
    trap_d    = trap_q | (state_d == S_ILLEGAL);
  end

  // Write enables are gated off while reset is held so nothing is disturbed.
  assign PCWrite    = pc_we  & ~reset;
  assign MemWrite   = mem_we & ~reset;
  assign IRWrite    = ir_we  & ~reset;
  assign RegWrite   = reg_we & ~reset;
  assign ImmSrc     = imm_src(op);
  assign instr_done = retire;
  assign instret    = instret_q;
  assign trap       = trap_q;

endmodule

// File: tb/tb_core_multicycle_ctrl.sv
// tb/tb_core_multicycle_ctrl.sv - table-driven scoreboard bench for core_multicycle_ctrl
module tb_core_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        Zero;
  logic        mem_ready;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic        instr_done;
  logic [31:0] instret;
  logic        trap;

  core_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .instr_done(instr_done),
    .instret(instret), .trap(trap)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] T_F = 4'd0, T_D = 4'd1, T_MA = 4'd2, T_MR = 4'd3,
                         T_MWB = 4'd4, T_MWR = 4'd5, T_ER = 4'd6, T_EI = 4'd7,
                         T_AWB = 4'd8, T_BEQ = 4'd9, T_JAL = 4'd10, T_ILL = 4'd11;

  typedef struct packed {
    logic [6:0]      op;
    logic [2:0]      f3;
    logic            f7;
    logic            z;
    logic [2:0]      len;
    logic [4:0][3:0] path;
    logic [2:0]      alu;
    logic [1:0]      imm;
    logic            retire;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_instret = 32'd0;
  logic [17:0] sb_q[$];
  vec_t        vecs[12];
  logic [17:0] obs;

  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUControl, ImmSrc, instr_done, trap};

  // Expected control word for one state, written straight from the state table.
  function automatic logic [17:0] ew(input logic [3:0] st, input logic [2:0] alu,
                                     input logic [1:0] imm, input logic z);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, done = 0, tr = 0;
    logic [1:0] rs = 0, a = 0, b = 0;
    logic [2:0] ac = 0;
    case (st)
      T_F:   begin pcw = 1; irw = 1; rs = 2'b10; b = 2'b10; end
      T_D:   begin a = 2'b01; b = 2'b01; end
      T_MA:  begin a = 2'b10; b = 2'b01; end
      T_MR:  adr = 1;
      T_MWB: begin rs = 2'b01; rw = 1; done = 1; end
      T_MWR: begin adr = 1; mw = 1; done = 1; end
      T_ER:  begin a = 2'b10; ac = alu; end
      T_EI:  begin a = 2'b10; b = 2'b01; ac = alu; end
      T_AWB: begin rw = 1; done = 1; end
      T_BEQ: begin a = 2'b10; ac = 3'b001; pcw = z; done = 1; end
      T_JAL: begin a = 2'b01; b = 2'b10; pcw = 1; end
      default: tr = 1;
    endcase
    return {pcw, adr, mw, irw, rw, rs, a, b, ac, imm, done, tr};
  endfunction

  function automatic vec_t mkv(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                               input logic z, input logic [2:0] len,
                               input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] p2,
                               input logic [3:0] p3, input logic [3:0] p4,
                               input logic [2:0] alu, input logic [1:0] imm, input logic ret);
    vec_t v;
    v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.len = len;
    v.path = {p4, p3, p2, p1, p0};
    v.alu = alu; v.imm = imm; v.retire = ret;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Drive one instruction, queue its expected words, then pop one per cycle.
  task automatic run_vec(input vec_t v, input int idx, input int ncyc, input bit adv_last);
    logic [17:0] want;
    op = v.op; funct3 = v.f3; funct7b5 = v.f7; Zero = v.z;
    for (int i = 0; i < ncyc; i++) sb_q.push_back(ew(v.path[i], v.alu, v.imm, v.z));
    for (int i = 0; i < ncyc; i++) begin
      #1;
      want = sb_q.pop_front();
      chk($sformatf("v%0d cyc%0d ctrl", idx, i), {14'd0, obs}, {14'd0, want});
      if (i < ncyc - 1 || adv_last) @(negedge clk);
    end
    if (adv_last) begin
      if (v.retire) exp_instret++;
      chk($sformatf("v%0d instret", idx), instret, exp_instret);
    end
  endtask

  task automatic ill_hold(input int n, input int idx);
    logic [17:0] want;
    for (int i = 0; i < n; i++) sb_q.push_back(ew(T_ILL, 3'b000, 2'b00, 1'b0));
    for (int i = 0; i < n; i++) begin
      #1;
      want = sb_q.pop_front();
      chk($sformatf("ill%0d hold%0d", idx, i), {14'd0, obs}, {14'd0, want});
      @(negedge clk);
    end
    chk($sformatf("ill%0d instret", idx), instret, exp_instret);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, " enables"}, {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
    chk({tag, " instret"}, instret, 32'd0);
    chk({tag, " trap"}, {31'd0, trap}, 32'd0);
    chk({tag, " fetch sel"}, {27'd0, AdrSrc, ResultSrc, ALUSrcB}, {27'd0, 1'b0, 2'b10, 2'b10});
    @(negedge clk);
    reset = 1'b0;
    exp_instret = 32'd0;
  endtask

  initial begin
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;

    vecs[0]  = mkv(7'b0000011, 3'b010, 0, 0, 5, T_F, T_D, T_MA, T_MR, T_MWB, 3'b000, 2'b00, 1);
    vecs[1]  = mkv(7'b0100011, 3'b010, 0, 0, 4, T_F, T_D, T_MA, T_MWR, 0,    3'b000, 2'b01, 1);
    vecs[2]  = mkv(7'b0110011, 3'b000, 0, 0, 4, T_F, T_D, T_ER, T_AWB, 0,    3'b000, 2'b00, 1);
    vecs[3]  = mkv(7'b0110011, 3'b000, 1, 0, 4, T_F, T_D, T_ER, T_AWB, 0,    3'b001, 2'b00, 1);
    vecs[4]  = mkv(7'b0110011, 3'b111, 0, 0, 4, T_F, T_D, T_ER, T_AWB, 0,    3'b010, 2'b00, 1);
    vecs[5]  = mkv(7'b0110011, 3'b110, 0, 1, 4, T_F, T_D, T_ER, T_AWB, 0,    3'b011, 2'b00, 1);
    vecs[6]  = mkv(7'b0110011, 3'b010, 0, 0, 4, T_F, T_D, T_ER, T_AWB, 0,    3'b101, 2'b00, 1);
    vecs[7]  = mkv(7'b0010011, 3'b000, 1, 0, 4, T_F, T_D, T_EI, T_AWB, 0,    3'b000, 2'b00, 1);
    vecs[8]  = mkv(7'b0010011, 3'b010, 0, 0, 4, T_F, T_D, T_EI, T_AWB, 0,    3'b101, 2'b00, 1);
    vecs[9]  = mkv(7'b1100011, 3'b000, 0, 1, 3, T_F, T_D, T_BEQ, 0, 0,       3'b000, 2'b10, 1);
    vecs[10] = mkv(7'b1100011, 3'b000, 0, 0, 3, T_F, T_D, T_BEQ, 0, 0,       3'b000, 2'b10, 1);
    vecs[11] = mkv(7'b1101111, 3'b000, 0, 0, 4, T_F, T_D, T_JAL, T_AWB, 0,   3'b000, 2'b11, 1);

    @(negedge clk);
    do_reset("por");

    for (int k = 0; k < 12; k++) run_vec(vecs[k], k, int'(vecs[k].len), 1'b1);

    // Abort a load in MEMREAD, then a clean load counts from zero.
    run_vec(vecs[0], 100, 4, 1'b0);
    #1;
    do_reset("mid-memread");
    run_vec(vecs[0], 101, 5, 1'b1);

    // Unknown opcode traps after DECODE and stays quiet.
    run_vec(mkv(7'b1111111, 3'b000, 0, 0, 3, T_F, T_D, T_ILL, 0, 0, 3'b000, 2'b00, 0), 102, 3, 1'b1);
    ill_hold(10, 102);
    do_reset("after-ill-op");

    // Unsupported funct3 traps from EXECUTER without a register write.
    run_vec(mkv(7'b0110011, 3'b001, 0, 0, 4, T_F, T_D, T_ER, T_ILL, 0, 3'b000, 2'b00, 0), 103, 4, 1'b1);
    ill_hold(2, 103);
    do_reset("after-ill-funct");

`ifdef CORE_MEM_WAIT_EN
    begin
      int  fc  = 0;
      int  pcw = 0;
      bit  seen = 0;
      op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
        if (c == 3) mem_ready = 1'b1;
        #1;
        fc++;
        pcw += int'(PCWrite);
        if (IRWrite) seen = 1;
        @(negedge clk);
      end
      chk("wait fetch cycles", fc, 32'd4);
      chk("wait pcwrite pulses", pcw, 32'd1);
      run_vec(mkv(7'b0000011, 3'b010, 0, 0, 4, T_D, T_MA, T_MR, T_MWB, 0, 3'b000, 2'b00, 1), 104, 4, 1'b1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/core_multicycle_ctrl.md
# core_multicycle_ctrl

Moore-style control FSM that sequences a multicycle RV32I-subset core datapath through fetch, decode, execute, memory and writeback. It drives the shared-ALU, register-file, memory and PC enables and mux selects, one state per clock. It also provides a retired-instruction counter and a sticky illegal-instruction trap. It sits beside the datapath and the unified instruction/data memory.

## Interface
- No parameters.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `op` in 7: instruction bits [6:0] from the instruction register.
- `funct3` in 3: instruction bits [14:12].
- `funct7b5` in 1: instruction bit 30.
- `Zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access complete; used only when `CORE_MEM_WAIT_EN` is defined.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: data memory write enable.
- `IRWrite` out 1: instruction register and OldPC enable.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: result select; 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: ALU A select; 00 = PC, 01 = OldPC, 10 = RD1.
- `ALUSrcB` out 2: ALU B select; 00 = RD2, 01 = ImmExt, 10 = constant 4.
- `ALUControl` out 3: ALU operation; 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ImmSrc` out 2: immediate format; 00 I, 01 S, 10 B, 11 J.
- `instr_done` out 1: one-cycle pulse when an instruction retires.
- `instret` out 32: retired-instruction count.
- `trap` out 1: illegal instruction detected; sticky.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ILLEGAL.
- FETCH:
  - Outputs: AdrSrc=0, IRWrite=1, A=00, B=10, add, ResultSrc=10, PCWrite=1.
  - Next state: DECODE.
- DECODE:
  - Outputs: A=01, B=01, add (branch target latched into ALUOut).
  - Next state by `op`: 0000011/0100011→MEMADR; 0110011→EXECUTER; 0010011→EXECUTEI; 1100011→BEQ; 1101111→JAL; any other→ILLEGAL.
- MEMADR:
  - Outputs: A=10, B=01, add.
  - Next state: `op[5]` ? MEMWRITE : MEMREAD.
- MEMREAD: AdrSrc=1, ResultSrc=00; next MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1; next FETCH.
- EXECUTER / EXECUTEI:
  - Outputs: A=10; B=00 (R) or 01 (I); ALUControl from funct decode.
  - Next state: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
- BEQ:
  - Outputs: A=10, B=00, sub, ResultSrc=00, PCWrite=`Zero`.
  - Next state: FETCH.
- JAL:
  - Outputs: A=01, B=10, add, ResultSrc=00, PCWrite=1.
  - Next state: ALUWB.
- Funct decode (EXECUTER/EXECUTEI), selected by funct3:
  - 000: sub when `op[5]&funct7b5`, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other funct3 goes to ILLEGAL on the next edge instead of ALUWB; no register write occurs.
- ImmSrc is decoded from `op` in every state; 00 for unknown opcodes.
- ILLEGAL:
  - All enables 0; `trap`=1.
  - Held until `reset`.
- Enables not listed for a state are 0; unlisted selects are 00 and ALUControl is add.
- `instr_done` is high for one cycle on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
- `instret` increments on each `instr_done` and wraps 0xFFFFFFFF→0.

## Timing
- Reset:
  - State goes to FETCH, `instret`=0, `trap`=0.
  - While `reset` is high, PCWrite, IRWrite, RegWrite and MemWrite are forced 0 combinationally.
- Reset asserted mid-instruction aborts it; no count is recorded and the first edge after release executes FETCH.
- Outputs are combinational from the state register and `op`/`funct3`/`Zero`; no output registers.
- Cycles per instruction: lw 5; sw, R-type, I-type and jal 4; beq 3.

## Configuration
- `CORE_MEM_WAIT_EN` defined:
  - FETCH, MEMREAD and MEMWRITE hold their state while `mem_ready`=0.
  - In FETCH, IRWrite and PCWrite assert only in the cycle `mem_ready`=1, so the PC advances exactly once.
  - In MEMWRITE, MemWrite is held high throughout the wait.
- `CORE_MEM_WAIT_EN` undefined: `mem_ready` is ignored and every state lasts one cycle.

## Structure
- `core_ctrl_pkg` holds:
  - the state enum;
  - opcode constants;
  - ALUControl, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings.
- Sub-module `core_alu_decoder`: combinational ALUOp (add/sub/funct) plus funct3/funct7b5/`op[5]` → ALUControl and an illegal flag.

## Test plan
- Reset pulse mid-MEMREAD → state FETCH, `instret`=0, all write enables 0 while reset is high.
- `op`=0000011 sequence → FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5; `instret` 0→1.
- `op`=1100011 with `Zero`=1, then again with `Zero`=0 → PCWrite=1 in BEQ for the first, 0 for the second; 3 cycles each.
- `op`=0110011, funct3=000, funct7b5=1 → ALUControl=001 in EXECUTER; funct3=111 → 010.
- `op`=1111111 → ILLEGAL after DECODE; `trap`=1; no further enables for 10 cycles.
- `CORE_MEM_WAIT_EN` defined, `mem_ready` low for 3 cycles in FETCH → PCWrite asserted exactly once; fetch lasts 4 cycles.
